common_stream_transmitter: RTL and testbench

//   Transmitter end of the valid/ready stream protocol consumed by common_bypass_buffer.

---
 rtl/common_stream_transmitter_if.sv | 29 ++
 rtl/common_stream_transmitter.sv | 115 +++++++++++
 tb/tb_common_stream_transmitter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/common_stream_transmitter_if.sv
// Stream transmitter bus: the push side (enqueue, status, flush) and the
// registered valid/ready output stream. The master modport is the
// transmitter's view; the slave modport is the view of whatever surrounds it.
interface common_stream_transmitter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] push_i_data;
    logic                  push_i_valid;
    logic                  push_o_full;
    logic [CNT_W-1:0]      push_o_count;
    logic                  push_o_overflow;
    logic                  flush_i;
    logic [DATA_WIDTH-1:0] next_o_data;
    logic                  next_o_valid;
    logic                  next_i_ready;

    modport master (
        input  push_i_data, push_i_valid, flush_i, next_i_ready,
        output push_o_full, push_o_count, push_o_overflow, next_o_data, next_o_valid
    );

    modport slave (
        output push_i_data, push_i_valid, flush_i, next_i_ready,
        input  push_o_full, push_o_count, push_o_overflow, next_o_data, next_o_valid
    );
endinterface

// File: rtl/common_stream_transmitter.sv
// Stream transmitter: unthrottled push port into a small FIFO backing a
// registered output stage. Total capacity is the output register plus
// DEPTH-1 FIFO entries. Every output comes straight from a flop.
module common_stream_transmitter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    common_stream_transmitter_if.master   bus
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int FIFO_N = DEPTH - 1;
    localparam int PTR_W  = (FIFO_N > 1) ? $clog2(FIFO_N) : 1;

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t            mem [FIFO_N];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_n;
    logic             oreg_valid_q, oreg_valid_n;
    word_t            oreg_data_q, oreg_data_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [CNT_W-1:0] fifo_cnt;
    logic             full_q, full_n;
    logic             ovf_q, ovf_n;
    logic             pop, push, fifo_wr;

    // FIFO size need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_N - 1)) ? '0 : p + 1'b1;
    endfunction

    // FIFO occupancy is the total count minus the word held in the output register.
    assign fifo_cnt = count_q - CNT_W'(oreg_valid_q);
    assign pop      = oreg_valid_q & bus.next_i_ready;
    // Full is registered, so a push in a full cycle is rejected even if a pop frees a slot.
    assign push     = bus.push_i_valid & ~full_q;

    // Next-state: output register refill priority, FIFO pointers, occupancy and status.
    always_comb begin
        oreg_valid_n = oreg_valid_q;
        oreg_data_n  = oreg_data_q;
        rd_ptr_n     = rd_ptr_q;
        wr_ptr_n     = wr_ptr_q;
        fifo_wr      = 1'b0;
        count_n      = count_q;
        ovf_n        = ovf_q | (bus.push_i_valid & full_q & ~bus.flush_i);

        if (bus.flush_i) begin
            // A presented word that is not taken must stay put; everything else is dropped.
            oreg_valid_n = oreg_valid_q & ~pop;
            rd_ptr_n     = '0;
            wr_ptr_n     = '0;
            count_n      = CNT_W'(oreg_valid_n);
        end else begin
            if (!oreg_valid_q || pop) begin
                if (fifo_cnt != '0) begin
                    oreg_valid_n = 1'b1;
                    oreg_data_n  = mem[rd_ptr_q];
                    rd_ptr_n     = ptr_inc(rd_ptr_q);
                    fifo_wr      = push;
                end else if (push) begin
                    oreg_valid_n = 1'b1;
                    oreg_data_n  = bus.push_i_data;
                end else begin
                    // Data is left alone so next_o_data holds its last value.
                    oreg_valid_n = 1'b0;
                end
            end else begin
                fifo_wr = push;
            end
            if (fifo_wr) begin
                wr_ptr_n = ptr_inc(wr_ptr_q);
            end
            count_n = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        full_n = (count_n == CNT_W'(DEPTH));
    end

    // Control and output-stage registers; reset dominates every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            oreg_valid_q <= 1'b0;
            oreg_data_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            oreg_valid_q <= oreg_valid_n;
            oreg_data_q  <= oreg_data_n;
            rd_ptr_q     <= rd_ptr_n;
            wr_ptr_q     <= wr_ptr_n;
            count_q      <= count_n;
            full_q       <= full_n;
            ovf_q        <= ovf_n;
        end
    end

    // FIFO storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!reset && fifo_wr) begin
            mem[wr_ptr_q] <= bus.push_i_data;
        end
    end

    assign bus.next_o_valid    = oreg_valid_q;
    assign bus.next_o_data     = oreg_data_q;
    assign bus.push_o_count    = count_q;
    assign bus.push_o_full     = full_q;
    assign bus.push_o_overflow = ovf_q;
endmodule

// File: tb/tb_common_stream_transmitter.sv
// Bench for common_stream_transmitter (DEPTH=4, DATA_WIDTH=32). Accepted
// pushes go into a scoreboard queue; a negedge monitor pops it on every
// transfer and also checks the hold-while-stalled rule.
module tb_common_stream_transmitter;
    localparam int DW = 32;
    localparam int DP = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [DW-1:0] sb [$];

    common_stream_transmitter_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    common_stream_transmitter #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitor and stall-stability monitor.
    logic          pv, pr, prst;
    logic [DW-1:0] pd;
    initial begin
        pv = 1'b0; pr = 1'b0; prst = 1'b1; pd = '0;
    end
    always @(negedge clk) begin
        logic [DW-1:0] exp_w;
        if (!reset) begin
            if (pv && !pr && !prst) begin
                checks++;
                if (bus.next_o_valid !== 1'b1 || bus.next_o_data !== pd) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%0b data=%h required valid=1 data=%h",
                             bus.next_o_valid, bus.next_o_data, pd);
                end
            end
            if (bus.next_o_valid === 1'b1 && bus.next_i_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got data=%h required no transfer", bus.next_o_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (bus.next_o_data !== exp_w) begin
                        failures++;
                        $display("FAIL sb_data got=%h required=%h", bus.next_o_data, exp_w);
                    end
                end
            end
        end
        pv   = bus.next_o_valid;
        pr   = bus.next_i_ready;
        pd   = bus.next_o_data;
        prst = reset;
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.push_i_valid = 1'b0;
        bus.push_i_data  = '0;
        bus.flush_i      = 1'b0;
        bus.next_i_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.next_o_valid !== 1'b0 || bus.next_o_data !== '0 || bus.push_o_count !== 3'd0 ||
            bus.push_o_full !== 1'b0 || bus.push_o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%0b d=%h c=%0d f=%0b o=%0b required all zero",
                     bus.next_o_valid, bus.next_o_data, bus.push_o_count,
                     bus.push_o_full, bus.push_o_overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bus.next_i_ready = 1'b1;
        bus.push_i_valid = 1'b1;
        bus.push_i_data  = 32'hA1;
        if (!bus.push_o_full) sb.push_back(bus.push_i_data);
        tick();
        bus.push_i_valid = 1'b0;
        checks++;
        if (bus.next_o_valid !== 1'b1 || bus.next_o_data !== 32'hA1 || bus.push_o_count !== 3'd1) begin
            failures++;
            $display("FAIL single_latency got v=%0b d=%h c=%0d required v=1 d=a1 c=1",
                     bus.next_o_valid, bus.next_o_data, bus.push_o_count);
        end
        tick();
        checks++;
        if (bus.next_o_valid !== 1'b0 || bus.push_o_count !== 3'd0) begin
            failures++;
            $display("FAIL single_drain got v=%0b c=%0d required v=0 c=0",
                     bus.next_o_valid, bus.push_o_count);
        end
    endtask

    task automatic test_full_overflow();
        bus.next_i_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.push_i_valid = 1'b1;
            bus.push_i_data  = DW'(i);
            if (!bus.push_o_full) sb.push_back(bus.push_i_data);
            tick();
            checks++;
            if (bus.push_o_count !== 3'((i < 4) ? i : 4) || bus.push_o_full !== (i >= 4) ||
                bus.push_o_overflow !== (i == 5)) begin
                failures++;
                $display("FAIL fill_step%0d got c=%0d f=%0b o=%0b required c=%0d f=%0b o=%0b",
                         i, bus.push_o_count, bus.push_o_full, bus.push_o_overflow,
                         (i < 4) ? i : 4, i >= 4, i == 5);
            end
        end
        bus.push_i_valid = 1'b0;
        bus.next_i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus.push_o_count !== 3'(4 - k) || bus.push_o_full !== 1'b0 || bus.next_o_valid !== (k < 4)) begin
                failures++;
                $display("FAIL drain_step%0d got c=%0d f=%0b v=%0b required c=%0d f=0 v=%0b",
                         k, bus.push_o_count, bus.push_o_full, bus.next_o_valid, 4 - k, k < 4);
            end
        end
        checks++;
        if (bus.push_o_overflow !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL overflow_sticky got o=%0b left=%0d required o=1 left=0",
                     bus.push_o_overflow, sb.size());
        end
    endtask

    task automatic test_stall();
        bus.next_i_ready = 1'b0;
        bus.push_i_valid = 1'b1;
        bus.push_i_data  = 32'hBEEF;
        if (!bus.push_o_full) sb.push_back(bus.push_i_data);
        tick();
        bus.push_i_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.next_o_valid !== 1'b1 || bus.next_o_data !== 32'hBEEF) begin
                failures++;
                $display("FAIL stall_cycle%0d got v=%0b d=%h required v=1 d=beef",
                         i, bus.next_o_valid, bus.next_o_data);
            end
            tick();
        end
        bus.next_i_ready = 1'b1;
        tick();
        checks++;
        if (bus.next_o_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL stall_release got v=%0b left=%0d required v=0 left=0",
                     bus.next_o_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        // Bypass path: FIFO stays empty, count pinned at 1.
        bus.next_i_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.push_i_valid = 1'b1;
            bus.push_i_data  = 32'h100 + DW'(i);
            if (!bus.push_o_full) sb.push_back(bus.push_i_data);
            tick();
            checks++;
            if (bus.push_o_count !== 3'd1 || bus.next_o_data !== 32'h100 + DW'(i)) begin
                failures++;
                $display("FAIL b2b_cycle%0d got c=%0d d=%h required c=1 d=%h",
                         i, bus.push_o_count, bus.next_o_data, 32'h100 + i);
            end
        end
        bus.push_i_valid = 1'b0;
        tick();
        // FIFO path: prefill so every steady-state word passes through the
        // FIFO and the pointers wrap many times.
        bus.next_i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.push_i_valid = 1'b1;
            bus.push_i_data  = 32'h200 + DW'(i);
            if (!bus.push_o_full) sb.push_back(bus.push_i_data);
            tick();
        end
        bus.next_i_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            bus.push_i_valid = 1'b1;
            bus.push_i_data  = 32'h300 + DW'(i);
            if (!bus.push_o_full) sb.push_back(bus.push_i_data);
            tick();
            checks++;
            if (bus.push_o_count !== 3'd3 || bus.push_o_full !== 1'b0) begin
                failures++;
                $display("FAIL wrap_cycle%0d got c=%0d f=%0b required c=3 f=0",
                         i, bus.push_o_count, bus.push_o_full);
            end
        end
        bus.push_i_valid = 1'b0;
        n = 0;
        while (bus.push_o_count !== 3'd0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.push_o_count !== 3'd0 || bus.next_o_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL wrap_drain got c=%0d v=%0b left=%0d required c=0 v=0 left=0 within 20 cycles",
                     bus.push_o_count, bus.next_o_valid, sb.size());
        end
    endtask

    task automatic test_flush();
        bus.next_i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.push_i_valid = 1'b1;
            bus.push_i_data  = 32'h10 + DW'(i);
            if (!bus.push_o_full) sb.push_back(bus.push_i_data);
            tick();
        end
        checks++;
        if (bus.push_o_count !== 3'd3) begin
            failures++;
            $display("FAIL flush_prefill got c=%0d required c=3", bus.push_o_count);
        end
        // Same-cycle push must be discarded along with the FIFO contents.
        bus.push_i_data = 32'h99;
        bus.flush_i     = 1'b1;
        tick();
        bus.flush_i      = 1'b0;
        bus.push_i_valid = 1'b0;
        sb.delete();
        sb.push_back(32'h10);
        checks++;
        if (bus.next_o_valid !== 1'b1 || bus.next_o_data !== 32'h10 || bus.push_o_count !== 3'd1 ||
            bus.push_o_full !== 1'b0) begin
            failures++;
            $display("FAIL flush_hold got v=%0b d=%h c=%0d f=%0b required v=1 d=10 c=1 f=0",
                     bus.next_o_valid, bus.next_o_data, bus.push_o_count, bus.push_o_full);
        end
        bus.next_i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.next_o_valid !== 1'b0 || bus.push_o_count !== 3'd0 || bus.next_o_data !== 32'h10) begin
                failures++;
                $display("FAIL flush_after%0d got v=%0b c=%0d d=%h required v=0 c=0 d=10",
                         i, bus.next_o_valid, bus.push_o_count, bus.next_o_data);
            end
        end
    endtask

    task automatic test_midstream_reset();
        bus.next_i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.push_i_valid = 1'b1;
            bus.push_i_data  = 32'h20 + DW'(i);
            if (!bus.push_o_full) sb.push_back(bus.push_i_data);
            tick();
        end
        checks++;
        if (bus.push_o_count !== 3'd3 || bus.next_o_valid !== 1'b1 || bus.push_o_overflow !== 1'b1) begin
            failures++;
            $display("FAIL mrst_pre got c=%0d v=%0b o=%0b required c=3 v=1 o=1",
                     bus.push_o_count, bus.next_o_valid, bus.push_o_overflow);
        end
        reset = 1'b1;
        bus.next_i_ready = 1'b1;
        tick();
        sb.delete();
        checks++;
        if (bus.next_o_valid !== 1'b0 || bus.next_o_data !== '0 || bus.push_o_count !== 3'd0 ||
            bus.push_o_full !== 1'b0 || bus.push_o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL mrst_state got v=%0b d=%h c=%0d f=%0b o=%0b required all zero",
                     bus.next_o_valid, bus.next_o_data, bus.push_o_count,
                     bus.push_o_full, bus.push_o_overflow);
        end
        reset = 1'b0;
        bus.push_i_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.next_o_valid !== 1'b0 || bus.push_o_count !== 3'd0) begin
            failures++;
            $display("FAIL mrst_idle got v=%0b c=%0d required v=0 c=0",
                     bus.next_o_valid, bus.push_o_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_full_overflow();
        test_stall();
        test_back_to_back();
        test_flush();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
